rr_stream_mux: RTL and testbench
================================

RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter N, default 4: number of input channels, range 2..16.
REQ-002 Parameter W, default 8: data width per channel, range 1..64.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-006 Port in_valid  input  N  per-channel valid.
REQ-007 Port in_ready  output  N  per-channel ready; combinational.
REQ-008 Port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-009 Port sel  input  clog2(N)  channel index used in fixed mode.
REQ-010 Port out_data  output  W  registered output data.
REQ-011 Port out_valid  output  1  registered output valid.
REQ-012 Port out_ready  input  1  downstream ready.
REQ-013 Port out_chan  output  clog2(N)  index of the channel that sourced out_data.

Function
REQ-014 Transfers SHALL occur only when valid and ready are both high in the same cycle, on every port.
REQ-015 load_en SHALL be (!out_valid | out_ready), so the output register accepts a new word while empty or while being drained.
REQ-016 At most one in_ready bit SHALL be high in any cycle: in_ready[i] = grant[i] & load_en.
REQ-017 In fixed mode, grant SHALL be one-hot at sel when in_valid[sel] = 1; otherwise grant SHALL be 0.
REQ-018 In fixed mode, sel >= N SHALL produce no grant.
REQ-019 In round-robin mode, grant SHALL go to the first i with in_valid[i] = 1, searching ptr, ptr+1, ... modulo N.
REQ-020 On each accepted round-robin grant to channel k, ptr SHALL become (k+1) mod N; k = N-1 SHALL wrap ptr to 0.
REQ-021 ptr SHALL NOT change in fixed mode or in cycles with no transfer.
REQ-022 Latency SHALL be exactly 1 cycle: a word accepted at edge t appears on out_data/out_chan with out_valid = 1 after edge t.
REQ-023 Throughput SHALL be one word per cycle while out_ready = 1.
REQ-024 With out_valid = 1 and out_ready = 0, out_data, out_chan and out_valid SHALL hold, and all in_ready SHALL be 0.
REQ-025 A drain with no grant in the same cycle (out_ready = 1, no valid candidate) SHALL clear out_valid at the next edge.
REQ-026 A drain and a new grant in the same cycle SHALL reload the register with the new word; out_valid stays 1.
REQ-027 Changes to mode or sel SHALL affect only the next arbitration and never modify a held output word.
REQ-028 in_ready SHALL NOT depend on out_data, and no input-to-output combinational path SHALL exist except out_ready/in_valid -> in_ready.

Reset
REQ-029 While rst = 1: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0, all in_ready = 0.
REQ-030 Asserting rst mid-transfer SHALL discard the held word immediately, without waiting for a clock edge.
REQ-031 The first grant after rst deasserts SHALL follow REQ-017/REQ-019 with ptr = 0.

Structure
REQ-032 A shared package SHALL define the mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
REQ-033 The round-robin search SHALL be a sub-module rr_arbiter (parameter N; inputs req[N], ptr; output one-hot gnt[N]), reusable elsewhere.
REQ-034 The output register and ptr SHALL be the only state; the expected implementation size is 120-400 lines.

Verification
REQ-035 Bench SHALL cover reset: rst pulsed during out_valid = 1 -> out_valid = 0 and out_data = 0 in the same cycle; ptr = 0 afterwards.
REQ-036 Bench SHALL cover round-robin fairness: N = 4, mode = 1, all in_valid = 1, out_ready = 1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3, one word per cycle.
REQ-037 Bench SHALL cover skipping and wrap: in_valid = 4'b1001 with ptr = 1 -> grants 3 then 0; ptr after the grant to 3 is 0.
REQ-038 Bench SHALL cover fixed mode: mode = 0, sel = 2, in_data ch2 = 8'hA5 -> out_data = 8'hA5 and out_chan = 2 one cycle later; other channels' in_ready = 0.
REQ-039 Bench SHALL cover backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> output stable and all in_ready = 0; out_ready = 1 -> drain plus reload in one cycle.
REQ-040 Bench SHALL cover an empty drain: out_ready = 1, all in_valid = 0 -> out_valid = 0 on the next cycle.

Source files
------------

// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
//   MODE_FIXED / MODE_RR : values of the mux 'mode' input.
//   next_ptr()           : rotation helper, returns the channel after k (mod n).
package rr_stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel following k in an n-channel ring; the last channel wraps to 0.
  function automatic int unsigned next_ptr(input int unsigned k, input int unsigned n);
    return (k == n - 1) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter (purely combinational).
//   req : per-requester request bits
//   ptr : index with highest priority this cycle; priority falls off
//         ptr, ptr+1, ... wrapping modulo N
//   gnt : one-hot grant to the first requester found, all-zero if none
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  // One extra bit so ptr + k never overflows before the modulo fold.
  localparam int IW = PW + 1;

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + IW'(k);
      if (idx >= IW'(N)) idx = idx - IW'(N);
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-to-1 valid/ready stream multiplexer with a one-word output register.
//   clk, rst             : clock, asynchronous active-high reset
//   in_data / in_valid   : N channels, channel i at in_data[i*W +: W]
//   in_ready             : combinational, at most one bit high per cycle
//   mode                 : MODE_FIXED picks channel 'sel', MODE_RR rotates
//   sel                  : channel index used in fixed mode
//   out_data / out_valid : registered output word
//   out_chan             : channel that sourced out_data
//   out_ready            : downstream ready
// State is only the output register and the round-robin pointer.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int PW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [PW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  out_chan
);

  logic [W-1:0]  out_data_q,  out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_chan_q,  out_chan_d;
  logic [PW-1:0] ptr_q,       ptr_d;

  logic [N-1:0]  gnt_rr, gnt_fix, gnt;
  logic          load_en, take;
  logic [W-1:0]  win_data;
  logic [PW-1:0] win_chan;

  rr_arbiter #(.N(N)) u_arb (
    .req (in_valid),
    .ptr (ptr_q),
    .gnt (gnt_rr)
  );

  // Fixed select: out-of-range sel (possible when N is not a power of 2)
  // must not grant anything.
  always_comb begin
    gnt_fix = '0;
    if (32'(sel) < 32'(N)) begin
      if (in_valid[sel]) gnt_fix[sel] = 1'b1;
    end
  end

  assign gnt     = (mode == MODE_RR) ? gnt_rr : gnt_fix;
  // Register can take a word when empty or when its word leaves this cycle.
  assign load_en = !out_valid_q || out_ready;
  assign take    = (|gnt) && load_en;
  // Reset masks ready directly so no handshake is seen while rst is held.
  assign in_ready = rst ? '0 : (gnt & {N{load_en}});

  // gnt is one-hot, so an OR-reduction acts as the mux and the encoder.
  always_comb begin
    win_data = '0;
    win_chan = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        win_data = win_data | in_data[i*W +: W];
        win_chan = win_chan | PW'(i);
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (take) begin
      out_data_d  = win_data;
      out_chan_d  = win_chan;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) ptr_d = PW'(next_ptr(32'(win_chan), N));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux (N=4, W=8) with an expected-word queue.
module tb_rr_stream_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [1:0]     sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_chan;

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  rr_stream_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic [7:0] d);
    exp_t e;
    e.chan = c;
    e.data = d;
    sbq.push_back(e);
  endtask

  // One clock: at the falling edge, a word that will leave at the next
  // rising edge is checked against the head of the queue.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_chan", 32'(out_chan), 32'(e.chan));
        chk("sb_data", 32'(out_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 4'hF;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_chan",  32'(out_chan),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;

    // Round-robin fairness: every channel valid, one word per cycle.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = {4'(c), 4'(i)};
      in_valid = 4'hF;
      push(2'(c % 4), {4'(c), 4'(c % 4)});
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'(1 << (c % 4)));
      cyc();
    end
    in_valid = 4'h0;
    cyc();
    chk("drain_empty_valid", 32'(out_valid), 32'd0);

    // Skip and wrap: ptr 0 -> grant 0 -> ptr 1; 1001 -> grant 3 -> ptr 0.
    in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
    in_valid = 4'b0001;
    push(2'd0, 8'h00);
    cyc();
    in_valid = 4'b1001;
    #1;
    chk("skip_in_ready", 32'(in_ready), 32'b1000);
    push(2'd3, 8'h33);
    cyc();
    #1;
    chk("wrap_ptr0_in_ready", 32'(in_ready), 32'b0001);
    push(2'd0, 8'h00);
    cyc();
    in_valid = 4'h0;
    cyc();
    chk("skip_drained", 32'(out_valid), 32'd0);

    // Fixed mode: sel=2 takes ch2 only.
    mode     = 1'b0;
    sel      = 2'd2;
    in_data  = {8'h44, 8'hA5, 8'h66, 8'h77};
    in_valid = 4'hF;
    #1;
    chk("fix_in_ready", 32'(in_ready), 32'b0100);
    push(2'd2, 8'hA5);
    cyc();
    sel      = 2'd1;
    in_valid = 4'b1101;
    #1;
    chk("fix_out_valid", 32'(out_valid), 32'd1);
    chk("fix_out_data",  32'(out_data),  32'hA5);
    chk("fix_out_chan",  32'(out_chan),  32'd2);
    chk("fix_nosel_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("fix_drained", 32'(out_valid), 32'd0);

    // Backpressure: ptr is still 1 (fixed mode left it alone).
    mode      = 1'b1;
    in_valid  = 4'hF;
    in_data   = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    out_ready = 1'b0;
    #1;
    chk("bp_first_in_ready", 32'(in_ready), 32'b0010);
    push(2'd1, 8'hD1);
    cyc();
    for (int h = 0; h < 3; h++) begin
      in_data = {4{8'(8'hE0 + h)}};
      #1;
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_chan",     32'(out_chan),  32'd1);
      chk("bp_data",     32'(out_data),  32'hD1);
      cyc();
    end
    in_data   = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'b0100);
    push(2'd2, 8'hF2);
    cyc();
    chk("bp_reload_valid", 32'(out_valid), 32'd1);
    chk("bp_reload_chan",  32'(out_chan),  32'd2);
    in_valid = 4'h0;
    cyc();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset while holding a word: ptr=3 -> ch0 granted and held.
    in_data   = {8'h00, 8'h00, 8'h00, 8'hC3};
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    #1;
    chk("pre_rst_in_ready", 32'(in_ready), 32'b0001);
    push(2'd0, 8'hC3);
    cyc();
    chk("pre_rst_data", 32'(out_data), 32'hC3);
    rst = 1'b1;
    #1;
    chk("async_rst_valid",    32'(out_valid), 32'd0);
    chk("async_rst_data",     32'(out_data),  32'd0);
    chk("async_rst_in_ready", 32'(in_ready),  32'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_data   = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ptr0", 32'(in_ready), 32'b0001);
    push(2'd0, 8'hB0);
    cyc();
    in_valid = 4'h0;
    cyc();
    chk("final_valid", 32'(out_valid), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
